lu_serial_ctrl: RTL and testbench
=================================

Name: lu_serial_ctrl

Overview:
- Bit-serial sequencer for the 1-bit, 7-operation logic unit.
- Accepts a WIDTH-bit operand pair and a 3-bit op code, then feeds the logic unit one bit per clock, LSB first.
- Collects the 1-bit results into a WIDTH-bit result word and signals completion with a done pulse.
- The logic unit is instantiated in the parent and connected through the lu_* ports.

Parameters:
WIDTH, 8, operand/result width in bits (≥2); cycle counter width = clog2(WIDTH)+1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
start  input  1  request; sampled only in IDLE
op  input  3  operation: 000 NOT a, 001 AND, 010 NAND, 011 XOR, 100 XNOR, 101 OR, 110 NOR, 111 illegal
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
lu_a  output  1  bit of A presented to logic unit
lu_b  output  1  bit of B presented to logic unit
lu_sel  output  3  op presented to logic unit
lu_s  input  1  logic unit result (combinational from lu_a/lu_b/lu_sel)
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse on illegal op
result  output  WIDTH  assembled result word

Behaviour:
- Reset (rst_n low, asynchronous, any state including mid-RUN):
  - State goes to IDLE; all outputs are 0; internal shift registers, op register and counter are 0.
  - A reset during RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0; lu_a=lu_b=0; lu_sel=000.
  - start=1 and op≠111: latch a→a_sh, b→b_sh, op→op_r; clear counter; go to RUN.
  - start=1 and op=111: stay in IDLE; err=1 for exactly the next cycle; result unchanged; no busy.
- RUN (exactly WIDTH cycles):
  - lu_a=a_sh[0], lu_b=b_sh[0], lu_sel=op_r.
  - Each rising edge: result_sh <= {lu_s, result_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1; counter+1.
  - For NOT, lu_b is still driven from b_sh but is ignored by the logic unit.
  - After the edge where counter reaches WIDTH-1: go to DONE.
- DONE (1 cycle):
  - done=1, busy=1; lu_a=lu_b=0; lu_sel=000.
  - result = fully assembled word: result[i] = op(a[i], b[i]).
  - Next state is IDLE.
- Latency: start sampled at edge 0 → RUN during cycles 1..WIDTH → done high in cycle WIDTH+1 → IDLE in cycle WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- result:
  - Register updates only when entering DONE; it is not visible mid-RUN.
  - Holds its value through IDLE until the next completed operation.
  - An illegal op does not change it.
- start while busy (RUN or DONE) is ignored with no queueing. a, b and op may change freely after acceptance.
- start held high continuously: re-accepted on the first IDLE cycle after DONE.
- err and done are never high in the same cycle.

Test Plan:
- Functional ops, WIDTH=8:
  - op=000, a=8'hA5 → result=8'h5A; done exactly 9 cycles after the start edge; busy high 9 cycles.
  - op=001, a=8'hF0, b=8'h3C → result=8'h30.
  - op=011, a=8'hFF, b=8'h0F → result=8'hF0.
  - op=110, a=8'h00, b=8'h00 → result=8'hFF.
  - op=100, a=8'hAA, b=8'hAA → result=8'hFF.
- Bit order check: during RUN with op=101, a=8'h01, b=8'h00 → lu_a=1 in the first RUN cycle only, then 0; result=8'h01.
- Illegal op: op=111, start=1 in IDLE → err=1 for one cycle; busy, done stay 0; result keeps its previous value (8'hFF).
- Start during busy:
  - Start op=001 with a=8'hFF, b=8'hFF; in RUN cycle 3 pulse start with op=000, a=8'h00.
  - Required: ignored; result=8'hFF; only one done pulse.
- Reset mid-RUN: drop rst_n in RUN cycle 4, between clock edges → busy, lu_a, lu_sel, result go to 0 immediately; no done pulse; a new start after release completes normally.
- Back-to-back: start held high with op=010, a=8'h0F, b=8'hFF → result=8'hF0 per pass; done pulses spaced 10 cycles apart.

Source files
------------

// File: rtl/lu_serial_ctrl.sv
// lu_serial_ctrl
//   Bit-serial sequencer for an external 1-bit, 7-operation logic unit.
//   A WIDTH-bit operand pair and a 3-bit op code are captured on start and
//   presented to the logic unit one bit per clock, LSB first. The 1-bit
//   results are shifted into a result word, which is published in the DONE
//   cycle together with a one-cycle done pulse.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, sampled only in IDLE
//   op      in   [2:0] 000 NOT a, 001 AND, 010 NAND, 011 XOR, 100 XNOR,
//                101 OR, 110 NOR, 111 illegal
//   a, b    in   [WIDTH-1:0] operands, sampled with start
//   lu_a    out  operand A bit to the logic unit
//   lu_b    out  operand B bit to the logic unit
//   lu_sel  out  [2:0] op code to the logic unit
//   lu_s    in   logic unit result (combinational from lu_a/lu_b/lu_sel)
//   busy    out  high in RUN and DONE
//   done    out  one-cycle completion pulse
//   err     out  one-cycle pulse after an illegal op request
//   result  out  [WIDTH-1:0] last completed result word
//
// Handshake: start acts as a valid with !busy as its ready. A request is
// taken only on a rising edge where the block is IDLE; requests while busy
// are dropped, not queued. a, b and op need only be stable on that edge.

module lu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lu_a,
    output logic             lu_b,
    output logic [2:0]       lu_sel,
    input  logic             lu_s,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result_sh;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             err_r;

    logic             accept;
    logic             reject;
    logic             last_bit;
    logic [WIDTH-1:0] result_sh_nx;

    assign accept       = (state == IDLE) && start && (op != OP_ILLEGAL);
    assign reject       = (state == IDLE) && start && (op == OP_ILLEGAL);
    assign last_bit     = (state == RUN) && (cnt == CNT_LAST);
    // The newest logic-unit bit enters at the MSB, so after WIDTH shifts
    // the bit computed from operand bit 0 has reached result bit 0.
    assign result_sh_nx = {lu_s, result_sh[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and logic-unit / status outputs
    always_comb begin
        state_nx = state;
        lu_a     = 1'b0;
        lu_b     = 1'b0;
        lu_sel   = 3'b000;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                lu_a   = a_sh[0];
                lu_b   = b_sh[0];
                lu_sel = op_r;
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, bit counter, result assembly, err pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            result_sh <= '0;
            op_r      <= '0;
            cnt       <= '0;
            err_r     <= 1'b0;
            result    <= '0;
        end else begin
            err_r <= reject;
            if (accept) begin
                a_sh      <= a;
                b_sh      <= b;
                op_r      <= op;
                cnt       <= '0;
                result_sh <= '0;
            end else if (state == RUN) begin
                a_sh      <= a_sh >> 1;
                b_sh      <= b_sh >> 1;
                cnt       <= cnt + 1'b1;
                result_sh <= result_sh_nx;
                if (last_bit) begin
                    result <= result_sh_nx;
                end
            end
        end
    end

    assign err = err_r;

endmodule

// File: tb/tb_lu_serial_ctrl.sv
module tb_lu_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         lu_a;
  logic         lu_b;
  logic [2:0]   lu_sel;
  logic         lu_s;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  lu_serial_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .lu_a   (lu_a),
    .lu_b   (lu_b),
    .lu_sel (lu_sel),
    .lu_s   (lu_s),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural 1-bit logic unit living in the parent
  always_comb begin
    case (lu_sel)
      3'b000:  lu_s = ~lu_a;
      3'b001:  lu_s = lu_a & lu_b;
      3'b010:  lu_s = ~(lu_a & lu_b);
      3'b011:  lu_s = lu_a ^ lu_b;
      3'b100:  lu_s = ~(lu_a ^ lu_b);
      3'b101:  lu_s = lu_a | lu_b;
      3'b110:  lu_s = ~(lu_a | lu_b);
      default: lu_s = 1'b0;
    endcase
  end

  // word-level reference: the whole result computed at once
  function automatic logic [W-1:0] ref_word(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      3'd0:    return ~x;
      3'd1:    return x & y;
      3'd2:    return ~(x & y);
      3'd3:    return x ^ y;
      3'd4:    return ~(x ^ y);
      3'd5:    return x | y;
      3'd6:    return ~(x | y);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // err and done must never coincide
  always @(negedge clk) begin
    if (rst_n && (err || done)) check("err_done_excl", {31'b0, err & done}, 32'd0);
  end

  // driver: one operation, checked bit by bit against the operands and
  // against the word model; poke>0 re-asserts start in that RUN cycle
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int poke);
    int lat;
    int n_busy;
    logic [W-1:0] expw;
    exp_q.push_back(ref_word(o, x, y));
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
    lat = 1; n_busy = 0;
    while (lat <= 20) begin
      if (lat <= W) begin
        check("lu_a", {31'b0, lu_a}, {31'b0, x[lat-1]});
        check("lu_b", {31'b0, lu_b}, {31'b0, y[lat-1]});
        check("lu_sel", {29'b0, lu_sel}, {29'b0, o});
      end
      if (busy) n_busy++;
      if (done) break;
      if (lat == poke) begin
        start = 1'b1; op = 3'b000; a = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    expw = exp_q.pop_front();
    if (lat > 20) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", lat, W + 1);
      check("busy_cycles", n_busy, W + 1);
      check("result", {24'b0, result}, {24'b0, expw});
      check("done_lu_a", {31'b0, lu_a}, 32'd0);
      check("done_lu_sel", {29'b0, lu_sel}, 32'd0);
      check("done_err", {31'b0, err}, 32'd0);
    end
    @(negedge clk);
    check("idle_done", {31'b0, done}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_result", {24'b0, result}, {24'b0, expw});
  endtask

  initial begin : main
    logic [W-1:0] prev;
    int last_done;
    int n_done;
    int k;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_result", {24'b0, result}, 32'd0);
    check("rst_lu", {29'b0, lu_sel} | {31'b0, lu_a} | {31'b0, lu_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed functional cases
    do_op(3'b000, 8'hA5, 8'h00, 0);
    do_op(3'b001, 8'hF0, 8'h3C, 0);
    do_op(3'b011, 8'hFF, 8'h0F, 0);
    do_op(3'b101, 8'h01, 8'h00, 0);
    do_op(3'b100, 8'hAA, 8'hAA, 0);
    do_op(3'b110, 8'h00, 8'h00, 0);

    // illegal op leaves result alone
    prev = result;
    start = 1'b1; op = 3'b111; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    check("ill_err", {31'b0, err}, 32'd1);
    check("ill_busy", {31'b0, busy}, 32'd0);
    check("ill_done", {31'b0, done}, 32'd0);
    check("ill_result", {24'b0, result}, {24'b0, prev});
    @(negedge clk);
    check("ill_err_pulse", {31'b0, err}, 32'd0);
    check("ill_result2", {24'b0, result}, 32'hFF);

    // start while busy is dropped
    do_op(3'b001, 8'hFF, 8'hFF, 3);

    // reset in RUN cycle 4, between edges
    start = 1'b1; op = 3'b001; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    check("pre_rst_lu_a", {31'b0, lu_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_lu_a", {31'b0, lu_a}, 32'd0);
    check("mid_rst_lu_sel", {29'b0, lu_sel}, 32'd0);
    check("mid_rst_result", {24'b0, result}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("post_rst_quiet", n_done, 0);
    do_op(3'b011, 8'h5A, 8'h0F, 0);

    // randomized operations
    for (int i = 0; i < 30; i++) begin
      do_op(3'($urandom_range(0, 6)), W'($urandom), W'($urandom), 0);
    end

    // back-to-back with start held high
    start = 1'b1; op = 3'b010; a = 8'h0F; b = 8'hFF;
    last_done = -1; n_done = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (done) begin
        check("b2b_result", {24'b0, result}, {24'b0, ref_word(3'b010, 8'h0F, 8'hFF)});
        if (last_done >= 0) check("b2b_spacing", cyc - last_done, W + 2);
        last_done = cyc;
        n_done++;
      end
    end
    start = 1'b0;
    check("b2b_count", n_done, 4);
    k = 0;
    while (busy && k < 15) begin
      @(negedge clk);
      k++;
    end
    check("b2b_drain", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
